pcpi_matrix_sequencer: RTL

PCPI initiator that drives the fused 3x3 matrix-multiply coprocessor in place of a CPU core.
- Accepts host commands (load element, run, stop) through a valid/ready port into a small FIFO.
- Encodes each command as a custom-0 instruction and issues it on the PCPI bus.
- For run, waits for completion with a timeout and reports done/timeout/error status to the host.
- Sits between the TinyTapeout I/O front-end and the coprocessor.

---
 rtl/pcpi_matrix_sequencer_if.sv | 28 ++
 rtl/pcpi_matrix_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pcpi_matrix_sequencer_if.sv
// Host command port plus PCPI initiator bus for the matrix sequencer.
// The master modport is the sequencer's view; slave is the host/coprocessor side.
interface pcpi_matrix_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_wr;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        err;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, pcpi_wr, pcpi_wait, pcpi_ready,
    output cmd_ready, pcpi_valid, pcpi_insn, busy, done, timeout, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, pcpi_wr, pcpi_wait, pcpi_ready,
    input  cmd_ready, pcpi_valid, pcpi_insn, busy, done, timeout, err
  );
endinterface

// File: rtl/pcpi_matrix_sequencer.sv
// Queues host commands and replays them as custom-0 PCPI instructions to the
// 3x3 matrix coprocessor, tracking run completion with a bounded wait.
module pcpi_matrix_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 31
) (
  input  logic                           clk,
  input  logic                           resetn,
  pcpi_matrix_sequencer_if.master        bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_ONE = 1;
  localparam logic [TW-1:0] TMR_LIMIT = TW'(TIMEOUT);
  localparam logic [6:0]    OPC_CUSTOM0 = 7'b0001011;
  localparam logic [1:0]    OP_LOAD = 2'b00;
  localparam logic [1:0]    OP_STOP = 2'b01;
  localparam logic [1:0]    OP_RUN  = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_RUN_GUARD, S_RUN_WAIT} state_t;

  state_t        state_q, state_d;
  logic [22:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pcpi_valid_q, pcpi_valid_d;
  logic [31:0]   pcpi_insn_q, pcpi_insn_d;
  logic          done_q, done_d, timeout_q, timeout_d, err_q, err_d;

  logic          fifo_empty, fifo_full, push, pop;
  logic [1:0]    head_op;
  logic [4:0]    head_addr;
  logic [15:0]   head_data;
  logic          head_illegal, issued_run, timer_expired;
  logic          unused_status;

  function automatic logic [31:0] encode(input logic [1:0] op, input logic [4:0] addr,
                                         input logic [15:0] data);
    logic [31:0] insn;
    case (op)
      OP_LOAD: insn = {1'b0, data, 3'b000, addr, OPC_CUSTOM0};
      OP_STOP: insn = {1'b0, 16'h0000, 3'b101, 5'h00, OPC_CUSTOM0};
      OP_RUN:  insn = {1'b0, 16'h0000, 3'b111, 5'h00, OPC_CUSTOM0};
      default: insn = 32'h0000_0000;
    endcase
    return insn;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign push       = bus.cmd_valid && !fifo_full;
  assign {head_op, head_addr, head_data} = fifo_mem_q[rd_ptr_q];
  assign head_illegal  = (head_op == 2'b11) || ((head_op == OP_LOAD) && (head_addr > 5'd27));
  // The instruction register still holds the word just issued, so it tells ISSUE where to go.
  assign issued_run    = (pcpi_insn_q[14:12] == 3'b111);
  assign timer_expired = (timer_q == TMR_LIMIT);
  assign unused_status = bus.pcpi_wr ^ bus.pcpi_wait;

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_addr, bus.cmd_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State register (all flops).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= 32'h0000_0000;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      pcpi_valid_q <= pcpi_valid_d;
      pcpi_insn_q  <= pcpi_insn_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!fifo_empty && !head_illegal) state_d = S_ISSUE;
      S_ISSUE:     state_d = issued_run ? S_RUN_GUARD : S_GAP;
      S_GAP:       state_d = S_IDLE;
      S_RUN_GUARD: state_d = S_RUN_WAIT;
      S_RUN_WAIT:  if (bus.pcpi_ready || timer_expired) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    pop          = 1'b0;
    pcpi_valid_d = 1'b0;
    pcpi_insn_d  = pcpi_insn_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    err_d        = 1'b0;
    timer_d      = timer_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            err_d = 1'b1;
          end else begin
            pcpi_valid_d = 1'b1;
            pcpi_insn_d  = encode(head_op, head_addr, head_data);
          end
        end
      end
      // pcpi_ready here is the tail of the previous acknowledge, not this run's.
      S_RUN_GUARD: timer_d = '0;
      S_RUN_WAIT: begin
        timer_d = timer_q + TMR_ONE;
        if (bus.pcpi_ready)     done_d    = 1'b1;
        else if (timer_expired) timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready  = !fifo_full;
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = pcpi_insn_q;
  assign bus.busy       = !fifo_empty || (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.err        = err_q;
endmodule
